nunchuk_poll_ctrl: RTL and testbench

NUNCHUK_POLL_CTRL -- requirements
Module: nunchuk_poll_ctrl

---
 rtl/nunchuk_poll_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_nunchuk_poll_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/nunchuk_poll_ctrl.sv
// Nunchuk poller: init writes, pointer write, 6-byte read via a byte-level I2C master, atomic publish.
// Optional macro NUNCHUK_DECRYPT_EN: init writes 0x40=0x00 only, bytes stored as (b^0x17)+0x17.
module nunchuk_poll_ctrl #(
  parameter int         POLL_CYCLES = 100000,
  parameter int         CONV_CYCLES = 20000,
  parameter logic [6:0] DEV_ADDR    = 7'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_data,
  output logic       cmd_nack,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_data,
  input  logic       rsp_err,
  output logic [7:0] data_out [5:0],
  output logic       frame_valid,
  output logic       busy,
  output logic       err
);
  localparam logic [3:0] IDLE = 4'd0, INIT1 = 4'd1, INIT2 = 4'd2, POLL_WAIT = 4'd3, PTR = 4'd4,
                         CONV_WAIT = 4'd5, READ = 4'd6, PUBLISH = 4'd7, ABORT = 4'd8;
  localparam logic [1:0] OP_START = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_STOP = 2'd3;
  localparam int CNT_MAX = (POLL_CYCLES > CONV_CYCLES) ? POLL_CYCLES : CONV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
`ifdef NUNCHUK_DECRYPT_EN
  localparam logic [7:0] INIT_REG = 8'h40, INIT_VAL = 8'h00;
`else
  localparam logic [7:0] INIT_REG = 8'hF0, INIT_VAL = 8'h55;
`endif

  logic [3:0]       state_q, state_d, step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_valid_q, cmd_valid_d, wait_q, wait_d, init_done_q, init_done_d;
  logic             frame_valid_q, frame_valid_d, err_q, err_d;
  logic [7:0]       shadow_q [5:0];
  logic [7:0]       shadow_d [5:0];
  logic [7:0]       data_q [5:0];
  logic [7:0]       data_d [5:0];
  logic             cmd_last;
  logic [2:0]       rd_idx;
  logic [7:0]       rd_byte;

  assign rd_idx = step_q[2:0] - 3'd2;
`ifdef NUNCHUK_DECRYPT_EN
  assign rd_byte = (rsp_data ^ 8'h17) + 8'h17;
`else
  assign rd_byte = rsp_data;
`endif

  // Current command is a pure function of (state, step), so it stays stable until accepted.
  always_comb begin
    cmd_op   = OP_STOP;
    cmd_data = 8'h00;
    cmd_nack = 1'b0;
    cmd_last = 1'b0;
    if (state_q == ABORT) begin
      cmd_last = 1'b1;
    end else if (step_q == 4'd0) begin
      cmd_op = OP_START;
    end else if (step_q == 4'd1) begin
      cmd_op   = OP_WRITE;
      cmd_data = {DEV_ADDR, state_q == READ};
    end else begin
      case (state_q)
        INIT1, INIT2: begin
          if (step_q <= 4'd3) begin
            cmd_op = OP_WRITE;
            if (step_q == 4'd2) cmd_data = (state_q == INIT1) ? INIT_REG : 8'hFB;
            else                cmd_data = (state_q == INIT1) ? INIT_VAL : 8'h00;
          end else begin
            cmd_last = 1'b1;
          end
        end
        PTR: begin
          if (step_q == 4'd2) cmd_op = OP_WRITE;
          else                cmd_last = 1'b1;
        end
        READ: begin
          if (step_q <= 4'd7) begin
            cmd_op   = OP_READ;
            cmd_nack = (step_q == 4'd7);
          end else begin
            cmd_last = 1'b1;
          end
        end
        default: cmd_last = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    cmd_valid_d   = cmd_valid_q;
    wait_d        = wait_q;
    init_done_d   = init_done_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;
    shadow_d      = shadow_q;
    data_d        = data_q;
    case (state_q)
      IDLE: if (enable) state_d = init_done_q ? POLL_WAIT : INIT1;
      POLL_WAIT: begin
        if (!enable)                state_d = IDLE;
        else if (cnt_q == POLL_LAST) state_d = init_done_q ? PTR : INIT1;
        else                        cnt_d = cnt_q + CNT_W'(1);
      end
      CONV_WAIT: begin
        if (!enable)                state_d = IDLE;
        else if (cnt_q == CONV_LAST) state_d = READ;
        else                        cnt_d = cnt_q + CNT_W'(1);
      end
      PUBLISH: state_d = enable ? POLL_WAIT : IDLE;
      default: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          wait_d      = 1'b1;
        end
        if (wait_q && rsp_valid) begin
          wait_d = 1'b0;
          if (cmd_op == OP_WRITE && rsp_err) begin
            err_d   = 1'b1;
            state_d = ABORT;
          end else begin
            if (cmd_op == OP_READ) shadow_d[rd_idx] = rd_byte;
            if (!cmd_last) begin
              step_d      = step_q + 4'd1;
              cmd_valid_d = 1'b1;
            end else begin
              case (state_q)
`ifdef NUNCHUK_DECRYPT_EN
                INIT1: begin
                  init_done_d = 1'b1;
                  state_d     = enable ? POLL_WAIT : IDLE;
                end
`else
                INIT1: state_d = enable ? INIT2 : IDLE;
`endif
                INIT2: begin
                  init_done_d = 1'b1;
                  state_d     = enable ? POLL_WAIT : IDLE;
                end
                PTR: state_d = enable ? CONV_WAIT : IDLE;
                READ: begin
                  state_d       = PUBLISH;
                  data_d        = shadow_q;
                  frame_valid_d = 1'b1;
                  err_d         = 1'b0;
                end
                default: begin
                  init_done_d = 1'b0;
                  state_d     = enable ? POLL_WAIT : IDLE;
                end
              endcase
            end
          end
        end
      end
    endcase
    // Every state entry restarts the step/wait bookkeeping; command phases raise their first command.
    if (state_d != state_q) begin
      step_d      = 4'd0;
      cnt_d       = '0;
      wait_d      = 1'b0;
      cmd_valid_d = state_d inside {INIT1, INIT2, PTR, READ, ABORT};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      step_q        <= 4'd0;
      cnt_q         <= '0;
      cmd_valid_q   <= 1'b0;
      wait_q        <= 1'b0;
      init_done_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= 8'h00;
      data_q[0] <= 8'h80;
      data_q[1] <= 8'h80;
      data_q[2] <= 8'h00;
      data_q[3] <= 8'h00;
      data_q[4] <= 8'h00;
      data_q[5] <= 8'h03;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      cmd_valid_q   <= cmd_valid_d;
      wait_q        <= wait_d;
      init_done_q   <= init_done_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      shadow_q      <= shadow_d;
      data_q        <= data_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign frame_valid = frame_valid_q;
  assign err         = err_q;
  assign data_out    = data_q;
  assign busy        = !(state_q inside {IDLE, POLL_WAIT});
endmodule

// File: tb/tb_nunchuk_poll_ctrl.sv
// Directed bench for nunchuk_poll_ctrl: expected command table plus reset, NACK, stall and enable sequences.
module tb_nunchuk_poll_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       rsp_err = 1'b0;
  logic [7:0] data_out [5:0];
  logic       frame_valid, busy, err;

  always #5 clk = ~clk;

  nunchuk_poll_ctrl #(.POLL_CYCLES(10), .CONV_CYCLES(5), .DEV_ADDR(7'h52)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_nack(cmd_nack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .data_out(data_out), .frame_valid(frame_valid), .busy(busy), .err(err)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] dat;
    logic       nack;
    logic [7:0] rdata;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] rbytes [6];
  int         n_vec = 0, n_bad = 0;
  int         ptr_i, rd_i;
  logic       stable_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] b);
`ifdef NUNCHUK_DECRYPT_EN
    return (b ^ 8'h17) + 8'h17;
`else
    return b;
`endif
  endfunction

  function automatic void add(input logic [1:0] op, input logic [7:0] dat, input logic nk, input logic [7:0] rd);
    vec_t v;
    v.op = op; v.dat = dat; v.nack = nk; v.rdata = rd;
    vt.push_back(v);
  endfunction

  function automatic logic [47:0] frame_word();
    return {data_out[0], data_out[1], data_out[2], data_out[3], data_out[4], data_out[5]};
  endfunction

  // Byte-level master model: wait for a command, stall dly cycles, accept, then pulse the response.
  task automatic do_cmd(input int dly, input logic [7:0] rd, input logic re,
                        output logic [1:0] op, output logic [7:0] dat, output logic nk, output logic got);
    int n = 0;
    got = 1'b0; op = 2'd0; dat = 8'h00; nk = 1'b0;
    while (!cmd_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) return;
    got = 1'b1; op = cmd_op; dat = cmd_data; nk = cmd_nack;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_op !== op || cmd_data !== dat || cmd_nack !== nk) stable_bad = 1'b1;
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    rsp_valid = 1'b1; rsp_data = rd; rsp_err = re;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_data = 8'h00;
  endtask

  function automatic logic [10:0] cmd_key(input logic [1:0] op, input logic [7:0] dat, input logic nk);
    return {op, (op == 2'd1) ? dat : 8'h00, nk};
  endfunction

  task automatic run_vecs(input int dly, input int first, input int last);
    logic [1:0] op; logic [7:0] dat; logic nk, got;
    for (int i = first; i < last; i++) begin
      do_cmd(dly, vt[i].rdata, 1'b0, op, dat, nk, got);
      if (!got) chk($sformatf("cmd%0d_timeout", i), 64'(got), 64'd1);
      else chk($sformatf("cmd%0d", i), 64'(cmd_key(op, dat, nk)), 64'(cmd_key(vt[i].op, vt[i].dat, vt[i].nack)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    logic [47:0] exp;
    exp = {stored(rbytes[0]), stored(rbytes[1]), stored(rbytes[2]),
           stored(rbytes[3]), stored(rbytes[4]), stored(rbytes[5])};
    chk({tag, "_frame_valid"}, 64'(frame_valid), 64'd1);
    chk({tag, "_data_out"}, 64'(frame_word()), 64'(exp));
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [1:0] op; logic [7:0] dat; logic nk, got;
    int n;
`ifdef NUNCHUK_DECRYPT_EN
    rbytes = '{8'h00, 8'h81, 8'h12, 8'h34, 8'h56, 8'hFE};
`else
    rbytes = '{8'h7F, 8'h81, 8'h12, 8'h34, 8'h56, 8'hFE};
`endif
    add(2'd0, 8'h00, 1'b0, 8'h00);
    add(2'd1, 8'hA4, 1'b0, 8'h00);
`ifdef NUNCHUK_DECRYPT_EN
    add(2'd1, 8'h40, 1'b0, 8'h00);
    add(2'd1, 8'h00, 1'b0, 8'h00);
    add(2'd3, 8'h00, 1'b0, 8'h00);
`else
    add(2'd1, 8'hF0, 1'b0, 8'h00);
    add(2'd1, 8'h55, 1'b0, 8'h00);
    add(2'd3, 8'h00, 1'b0, 8'h00);
    add(2'd0, 8'h00, 1'b0, 8'h00);
    add(2'd1, 8'hA4, 1'b0, 8'h00);
    add(2'd1, 8'hFB, 1'b0, 8'h00);
    add(2'd1, 8'h00, 1'b0, 8'h00);
    add(2'd3, 8'h00, 1'b0, 8'h00);
`endif
    ptr_i = vt.size();
    add(2'd0, 8'h00, 1'b0, 8'h00);
    add(2'd1, 8'hA4, 1'b0, 8'h00);
    add(2'd1, 8'h00, 1'b0, 8'h00);
    add(2'd3, 8'h00, 1'b0, 8'h00);
    rd_i = vt.size();
    add(2'd0, 8'h00, 1'b0, 8'h00);
    add(2'd1, 8'hA5, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) add(2'd2, 8'h00, (i == 5), rbytes[i]);
    add(2'd3, 8'h00, 1'b0, 8'h00);

    // Reset state
    do_reset();
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data_out", 64'(frame_word()), 64'h8080_0000_0003);

    // Full poll sequence, master always ready
    enable = 1'b1;
    run_vecs(0, 0, vt.size());
    check_frame("main");
`ifdef NUNCHUK_DECRYPT_EN
    chk("decrypt_byte0", 64'(data_out[0]), 64'h2E);
`endif
    @(negedge clk);
    chk("frame_valid_pulse", 64'(frame_valid), 64'd0);

    // enable low while waiting: no commands, then resume at PTR since init is done
    enable = 1'b0;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (cmd_valid) n++;
    end
    chk("disabled_no_cmd", 64'(n), 64'd0);
    chk("disabled_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    run_vecs(0, ptr_i, ptr_i + 3);

    // NACK on the first init register write
    do_reset();
    enable = 1'b1;
    run_vecs(0, 0, 2);
    do_cmd(0, 8'h00, 1'b1, op, dat, nk, got);
    chk("nack_cmd", 64'(cmd_key(op, dat, nk)), 64'(cmd_key(vt[2].op, vt[2].dat, vt[2].nack)));
    chk("nack_err_set", 64'(err), 64'd1);
    do_cmd(0, 8'h00, 1'b0, op, dat, nk, got);
    chk("abort_stop", 64'({got, op}), 64'({1'b1, 2'd3}));
    chk("abort_err_sticky", 64'(err), 64'd1);
    chk("abort_data_neutral", 64'(frame_word()), 64'h8080_0000_0003);
    run_vecs(0, 0, 3);

    // Master stalls 7 cycles per command
    do_reset();
    enable = 1'b1;
    stable_bad = 1'b0;
    run_vecs(7, 0, vt.size());
    check_frame("stall");
    chk("stall_cmd_stable", 64'(stable_bad), 64'd0);

    // Reset while the fourth READ is pending
    do_reset();
    enable = 1'b1;
    run_vecs(0, 0, rd_i + 5);
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("read4_pending", 64'({cmd_valid, cmd_op}), 64'({1'b1, 2'd2}));
    rst = 1'b1;
    #1;
    chk("rst_async_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_mid_data_out", 64'(frame_word()), 64'h8080_0000_0003);
    chk("rst_mid_frame_valid", 64'(frame_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vecs(0, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
